// File: rtl/bj_card_dealer_if.sv
// Control/status bundle between the BlackJack card dealer and its driver.
// The master side drives the control inputs and the slave side is the dealer itself.
interface bj_card_dealer_if #(
    parameter int unsigned STA_WL = 160
);
    logic              i_ena;
    logic [15:0]       i_seed;
    logic              i_seed_load;
    logic              i_new_ep;
    logic              i_act_vld;
    logic              i_act;
    logic              i_inj_vld;
    logic [3:0]        i_inj_card;
    logic [STA_WL-1:0] o_sta;
    logic              o_valid;
    logic              o_busy;
    logic              o_overflow;

    modport master (
        output i_ena, i_seed, i_seed_load, i_new_ep, i_act_vld, i_act, i_inj_vld, i_inj_card,
        input  o_sta, o_valid, o_busy, o_overflow
    );

    modport slave (
        input  i_ena, i_seed, i_seed_load, i_new_ep, i_act_vld, i_act, i_inj_vld, i_inj_card,
        output o_sta, o_valid, o_busy, o_overflow
    );
endinterface

// File: rtl/bj_card_dealer.sv
// BlackJack card dealer: keeps the player/dealer card slots for one episode, draws cards from
// a 16-bit LFSR (or an injected card), deals the opening hand, appends on HIT and plays out the
// dealer on STICK. The packed slot word is published with a one-cycle o_valid pulse.
module bj_card_dealer #(
    parameter int unsigned STA_WL              = 160,
    parameter int unsigned CARD_WL             = 4,
    parameter int unsigned PLAYER_MAX_CARD_NUM = 21,
    parameter int unsigned DEALER_MAX_CARD_NUM = 17,
    parameter int unsigned DEALER_STAND        = 17,
    parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
    input logic             i_clk,
    input logic             i_rst,
    bj_card_dealer_if.slave bus
);
    localparam int unsigned DealerBase = PLAYER_MAX_CARD_NUM * CARD_WL;

    typedef enum logic [2:0] {StIdle, StDeal, StWaitAct, StHit, StDfill, StOut} state_e;

    state_e             state_q;
    logic [15:0]        lfsr_q;
    logic [CARD_WL-1:0] player_q [PLAYER_MAX_CARD_NUM];
    logic [CARD_WL-1:0] dealer_q [DEALER_MAX_CARD_NUM];
    logic [4:0]         p_cnt_q;
    logic [4:0]         d_cnt_q;
    logic [4:0]         d_hard_q;
    logic               d_ace_q;
    logic [1:0]         deal_idx_q;
    logic [STA_WL-1:0]  sta_q;
    logic               valid_q;
    logic               ovf_q;

    logic [3:0]         rank;
    logic [3:0]         draw_card;
    logic               draw_ok;
    logic [5:0]         hard_add;
    logic [4:0]         hard_sat;
    logic [4:0]         d_soft;
    logic               stand;
    logic               start_ep;
    logic               lfsr_fb;
    logic [STA_WL-1:0]  sta_pack;

    // Draw decode, dealer totals and episode-start qualification
    always_comb begin
        rank    = lfsr_q[3:0];
        // Ranks 13..15 are rejected so the 13 accepted ranks map onto a uniform deck
        draw_ok = bus.i_inj_vld || (rank <= 4'd12);
        if (bus.i_inj_vld) begin
            draw_card = bus.i_inj_card;
        end else if (rank >= 4'd9) begin
            draw_card = 4'd10;
        end else begin
            draw_card = rank + 4'd1;
        end
        hard_add = {1'b0, d_hard_q} + {2'b00, draw_card};
        hard_sat = hard_add[5] ? 5'd31 : hard_add[4:0];
        d_soft   = (d_ace_q && (d_hard_q <= 5'd11)) ? d_hard_q + 5'd10 : d_hard_q;
        stand    = d_soft >= 5'(DEALER_STAND);
        start_ep = bus.i_ena && bus.i_new_ep && ((state_q == StIdle) || (state_q == StWaitAct));
        lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    end

    // Pack the slot arrays into the state word, slot 0 in the LSBs
    always_comb begin
        sta_pack = '0;
        for (int i = 0; i < PLAYER_MAX_CARD_NUM; i++) begin
            sta_pack[i*CARD_WL +: CARD_WL] = player_q[i];
        end
        for (int i = 0; i < DEALER_MAX_CARD_NUM; i++) begin
            sta_pack[DealerBase + i*CARD_WL +: CARD_WL] = dealer_q[i];
        end
    end

    // Card source LFSR; a seed load takes precedence over the shift
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (bus.i_ena) begin
            if (bus.i_seed_load) begin
                lfsr_q <= (bus.i_seed == 16'd0) ? LFSR_SEED : bus.i_seed;
            end else begin
                lfsr_q <= {lfsr_q[14:0], lfsr_fb};
            end
        end
    end

    // Episode FSM with slot, counter and registered output updates
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            for (int i = 0; i < PLAYER_MAX_CARD_NUM; i++) player_q[i] <= '0;
            for (int i = 0; i < DEALER_MAX_CARD_NUM; i++) dealer_q[i] <= '0;
            p_cnt_q    <= '0;
            d_cnt_q    <= '0;
            d_hard_q   <= '0;
            d_ace_q    <= 1'b0;
            deal_idx_q <= '0;
            sta_q      <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start_ep) begin
                for (int i = 0; i < PLAYER_MAX_CARD_NUM; i++) player_q[i] <= '0;
                for (int i = 0; i < DEALER_MAX_CARD_NUM; i++) dealer_q[i] <= '0;
                p_cnt_q    <= '0;
                d_cnt_q    <= '0;
                d_hard_q   <= '0;
                d_ace_q    <= 1'b0;
                deal_idx_q <= '0;
                ovf_q      <= 1'b0;
                state_q    <= StDeal;
            end else if (bus.i_ena) begin
                unique case (state_q)
                    StWaitAct: begin
                        if (bus.i_act_vld) state_q <= bus.i_act ? StHit : StDfill;
                    end
                    StDeal: begin
                        if (draw_ok) begin
                            // Even steps feed the player, odd steps the dealer
                            if (!deal_idx_q[0]) begin
                                player_q[p_cnt_q] <= CARD_WL'(draw_card);
                                p_cnt_q           <= p_cnt_q + 5'd1;
                            end else begin
                                dealer_q[d_cnt_q] <= CARD_WL'(draw_card);
                                d_cnt_q           <= d_cnt_q + 5'd1;
                                d_hard_q          <= hard_sat;
                                if (draw_card == 4'd1) d_ace_q <= 1'b1;
                            end
                            deal_idx_q <= deal_idx_q + 2'd1;
                            if (deal_idx_q == 2'd3) state_q <= StOut;
                        end
                    end
                    StHit: begin
                        if (p_cnt_q == 5'(PLAYER_MAX_CARD_NUM)) begin
                            ovf_q   <= 1'b1;
                            state_q <= StOut;
                        end else if (draw_ok) begin
                            player_q[p_cnt_q] <= CARD_WL'(draw_card);
                            p_cnt_q           <= p_cnt_q + 5'd1;
                            state_q           <= StOut;
                        end
                    end
                    StDfill: begin
                        if (stand) begin
                            state_q <= StOut;
                        end else if (d_cnt_q == 5'(DEALER_MAX_CARD_NUM)) begin
                            ovf_q   <= 1'b1;
                            state_q <= StOut;
                        end else if (draw_ok) begin
                            dealer_q[d_cnt_q] <= CARD_WL'(draw_card);
                            d_cnt_q           <= d_cnt_q + 5'd1;
                            d_hard_q          <= hard_sat;
                            if (draw_card == 4'd1) d_ace_q <= 1'b1;
                        end
                    end
                    StOut: begin
                        sta_q   <= sta_pack;
                        valid_q <= 1'b1;
                        state_q <= StWaitAct;
                    end
                    default: ;  // StIdle only leaves through start_ep
                endcase
            end
        end
    end

    assign bus.o_sta      = sta_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_busy     = (state_q == StDeal) || (state_q == StHit) || (state_q == StDfill);
endmodule

// File: tb/tb_bj_card_dealer.sv
// Bench for bj_card_dealer: directed injected-card scenarios plus LFSR-driven random episodes,
// all predicted from the dealing rules applied to a per-edge record of the draw sources.
module tb_bj_card_dealer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] lfsr_m;
    logic [15:0] hist_lfsr [$];
    logic [4:0]  hist_inj  [$];
    int          pl [$];
    int          dl [$];
    bit          ovf_m;
    int          draws_total = 0;
    int          tens_total  = 0;

    bj_card_dealer_if bus ();

    bj_card_dealer dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference LFSR plus a record of what each rising edge could draw from
    always @(posedge clk) begin
        hist_lfsr.push_back(lfsr_m);
        hist_inj.push_back({bus.i_inj_vld, bus.i_inj_card});
        if (rst) begin
            lfsr_m <= 16'hACE1;
        end else if (bus.i_ena) begin
            if (bus.i_seed_load) lfsr_m <= (bus.i_seed == 16'd0) ? 16'hACE1 : bus.i_seed;
            else lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Card obtainable at edge k, or 0 when the LFSR rank is rejected
    function automatic bit draw_at(input int k, output int card);
        logic [3:0] r;
        card = 0;
        if (hist_inj[k][4]) begin
            card = int'(hist_inj[k][3:0]);
            return 1'b1;
        end
        r = hist_lfsr[k][3:0];
        if (r > 4'd12) return 1'b0;
        card = (r >= 4'd9) ? 10 : int'(r) + 1;
        return 1'b1;
    endfunction

    function automatic int dealer_soft();
        int hard = 0;
        bit ace  = 1'b0;
        foreach (dl[i]) begin
            hard += dl[i];
            if (dl[i] == 1) ace = 1'b1;
        end
        if (hard > 31) hard = 31;
        return (ace && (hard + 10 <= 21)) ? hard + 10 : hard;
    endfunction

    function automatic logic [159:0] model_sta();
        logic [159:0] s = '0;
        foreach (pl[i]) s[i*4 +: 4] = 4'(pl[i]);
        foreach (dl[i]) s[84 + i*4 +: 4] = 4'(dl[i]);
        return s;
    endfunction

    // Each model returns the edge index whose update should raise o_valid
    function automatic int model_deal(input int s);
        int k = s + 1;
        int n = 0;
        int c;
        pl.delete();
        dl.delete();
        ovf_m = 1'b0;
        while (n < 4) begin
            if (k >= hist_inj.size()) return -1;
            if (draw_at(k, c)) begin
                if (n % 2 == 0) pl.push_back(c);
                else dl.push_back(c);
                n++;
            end
            k++;
        end
        return k;
    endfunction

    function automatic int model_hit(input int a);
        int k = a + 1;
        int c;
        if (pl.size() >= 21) begin
            ovf_m = 1'b1;
            return a + 2;
        end
        while (k < hist_inj.size()) begin
            if (draw_at(k, c)) begin
                pl.push_back(c);
                return k + 1;
            end
            k++;
        end
        return -1;
    endfunction

    function automatic int model_stick(input int a);
        int k = a + 1;
        int c;
        while (k < hist_inj.size()) begin
            if (dealer_soft() >= 17) return k + 1;
            if (dl.size() >= 17) begin
                ovf_m = 1'b1;
                return k + 1;
            end
            if (draw_at(k, c)) dl.push_back(c);
            k++;
        end
        return -1;
    endfunction

    task automatic wait_valid(input string tag, output int e);
        e = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.o_valid === 1'b1) begin
                e = hist_lfsr.size() - 1;
                break;
            end
        end
        if (e < 0) check({tag, "_timeout"}, bus.o_valid, 1'b1);
    endtask

    task automatic check_episode(input string tag, input int got, input int exp);
        check({tag, "_edge"}, got, exp);
        check({tag, "_sta"}, bus.o_sta, model_sta());
        check({tag, "_ovf"}, bus.o_overflow, ovf_m);
        step();
        check({tag, "_pulse"}, bus.o_valid, 1'b0);
    endtask

    task automatic deal_inj(input int c0, input int c1, input int c2, input int c3,
                            output int e0);
        bus.i_inj_vld  = 1'b1;
        bus.i_new_ep   = 1'b1;
        e0             = hist_lfsr.size();
        step();
        bus.i_new_ep   = 1'b0;
        bus.i_inj_card = 4'(c0);
        step();
        bus.i_inj_card = 4'(c1);
        step();
        bus.i_inj_card = 4'(c2);
        step();
        bus.i_inj_card = 4'(c3);
    endtask

    task automatic act_inj(input bit hit, input int c0, input int c1, output int a);
        bus.i_inj_vld  = 1'b1;
        bus.i_act_vld  = 1'b1;
        bus.i_act      = hit;
        a              = hist_lfsr.size();
        step();
        bus.i_act_vld  = 1'b0;
        bus.i_inj_card = 4'(c0);
        step();
        bus.i_inj_card = 4'(c1);
    endtask

    task automatic start_ep(input bit with_act, output int e0);
        bus.i_inj_vld = 1'b0;
        bus.i_new_ep  = 1'b1;
        bus.i_act_vld = with_act;
        bus.i_act     = 1'b1;
        e0            = hist_lfsr.size();
        step();
        bus.i_new_ep  = 1'b0;
        bus.i_act_vld = 1'b0;
    endtask

    task automatic act(input bit hit, output int a);
        bus.i_act_vld = 1'b1;
        bus.i_act     = hit;
        a             = hist_lfsr.size();
        step();
        bus.i_act_vld = 1'b0;
    endtask

    initial begin
        int e0, v, a, nh, nv;
        logic [15:0] sd;

        bus.i_ena       = 1'b1;
        bus.i_seed      = '0;
        bus.i_seed_load = 1'b0;
        bus.i_new_ep    = 1'b0;
        bus.i_act_vld   = 1'b0;
        bus.i_act       = 1'b0;
        bus.i_inj_vld   = 1'b0;
        bus.i_inj_card  = '0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_sta", bus.o_sta, '0);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_ovf", bus.o_overflow, 1'b0);
        check("rst_lfsr", dut.lfsr_q, 16'hACE1);

        // Injected opening hand 5,7,9,1
        deal_inj(5, 7, 9, 1, e0);
        check("deal_busy", bus.o_busy, 1'b1);
        wait_valid("deal", v);
        check("deal_lat", v - e0, 5);
        check("deal_player", bus.o_sta[7:0], 8'h95);
        check("deal_dealer", bus.o_sta[91:84], 8'h17);
        check("deal_pad", bus.o_sta[159:152], 8'h00);
        check_episode("deal", v, model_deal(e0));

        // HIT with injected 10
        act_inj(1'b1, 10, 10, a);
        wait_valid("hit", v);
        check("hit_lat", v - a, 2);
        check("hit_slot2", bus.o_sta[11:8], 4'hA);
        check("hit_dealer", bus.o_sta[91:84], 8'h17);
        check_episode("hit", v, model_hit(a));
        check("hit_idle_busy", bus.o_busy, 1'b0);

        // STICK on soft 17 draws nothing
        deal_inj(2, 1, 3, 6, e0);
        wait_valid("deal_s17", v);
        check_episode("deal_s17", v, model_deal(e0));
        act_inj(1'b0, 9, 9, a);
        wait_valid("stick17", v);
        check("stick17_lat", v - a, 2);
        check("stick17_dealer", bus.o_sta[99:84], 16'h0061);
        check_episode("stick17", v, model_stick(a));

        // STICK from {2,3} draws 4 then 10
        deal_inj(5, 2, 5, 3, e0);
        wait_valid("deal_s19", v);
        check_episode("deal_s19", v, model_deal(e0));
        act_inj(1'b0, 4, 10, a);
        wait_valid("stick19", v);
        check("stick19_lat", v - a, 4);
        check("stick19_slots", bus.o_sta[99:92], 8'hA4);
        check_episode("stick19", v, model_stick(a));

        // Fill all player slots with aces, then one HIT too many
        deal_inj(1, 1, 1, 1, e0);
        wait_valid("deal_ovf", v);
        check_episode("deal_ovf", v, model_deal(e0));
        for (int h = 0; h < 20; h++) begin
            act_inj(1'b1, 1, 1, a);
            wait_valid("hit_ovf", v);
            if (h == 19) begin
                check("ovf_lat", v - a, 2);
                check("ovf_flag", bus.o_overflow, 1'b1);
                check("ovf_slot20", bus.o_sta[83:80], 4'h1);
            end
            check_episode("hit_ovf", v, model_hit(a));
        end
        deal_inj(3, 3, 3, 3, e0);
        wait_valid("deal_clr", v);
        check("ovf_cleared", bus.o_overflow, 1'b0);
        check_episode("deal_clr", v, model_deal(e0));

        // A HIT strobe during DEAL is dropped
        bus.i_new_ep   = 1'b1;
        e0             = hist_lfsr.size();
        step();
        bus.i_new_ep   = 1'b0;
        bus.i_act_vld  = 1'b1;
        bus.i_act      = 1'b1;
        bus.i_inj_card = 4'd8;
        step();
        bus.i_act_vld  = 1'b0;
        wait_valid("deal_ign", v);
        check_episode("deal_ign", v, model_deal(e0));
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.o_valid === 1'b1) nv++;
        end
        check("ign_no_valid", nv, 0);

        // i_ena low for three cycles stretches the deal
        bus.i_inj_card = 4'd3;
        bus.i_new_ep   = 1'b1;
        e0             = hist_lfsr.size();
        step();
        bus.i_new_ep   = 1'b0;
        step();
        bus.i_ena      = 1'b0;
        step();
        step();
        step();
        bus.i_ena      = 1'b1;
        wait_valid("ena", v);
        check("ena_lat", v - e0, 8);
        check("ena_player", bus.o_sta[7:0], 8'h33);
        check("ena_dealer", bus.o_sta[91:84], 8'h33);

        // Zero seed maps to the default seed; then a random nonzero seed
        bus.i_seed      = 16'h0000;
        bus.i_seed_load = 1'b1;
        step();
        bus.i_seed_load = 1'b0;
        check("seed_zero", dut.lfsr_q, 16'hACE1);
        sd              = 16'($urandom_range(1, 65535));
        bus.i_seed      = sd;
        bus.i_seed_load = 1'b1;
        step();
        bus.i_seed_load = 1'b0;
        check("seed_load", dut.lfsr_q, sd);

        // LFSR-driven random episodes
        for (int ep = 0; ep < 200; ep++) begin
            start_ep(ep % 5 == 0, e0);
            wait_valid("rnd_deal", v);
            check_episode("rnd_deal", v, model_deal(e0));
            nh = $urandom_range(0, 3);
            for (int h = 0; h < nh; h++) begin
                act(1'b1, a);
                wait_valid("rnd_hit", v);
                check_episode("rnd_hit", v, model_hit(a));
            end
            if ($urandom_range(0, 2) != 0) begin
                act(1'b0, a);
                wait_valid("rnd_stick", v);
                check_episode("rnd_stick", v, model_stick(a));
            end
            foreach (pl[i]) begin
                draws_total++;
                if (pl[i] == 10) tens_total++;
            end
            foreach (dl[i]) begin
                draws_total++;
                if (dl[i] == 10) tens_total++;
            end
        end
        check("ten_ratio", (tens_total * 13 >= draws_total * 3) &&
                           (tens_total * 13 <= draws_total * 5), 1'b1);

        // Reset in the middle of a dealer fill
        deal_inj(2, 2, 2, 2, e0);
        wait_valid("deal_rst", v);
        check_episode("deal_rst", v, model_deal(e0));
        act_inj(1'b0, 2, 2, a);
        step();
        check("dfill_busy", bus.o_busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", bus.o_busy, 1'b0);
        check("midrst_valid", bus.o_valid, 1'b0);
        check("midrst_sta", bus.o_sta, '0);
        check("midrst_lfsr", dut.lfsr_q, 16'hACE1);
        bus.i_act_vld = 1'b1;
        bus.i_act     = 1'b1;
        step();
        bus.i_act_vld = 1'b0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.o_valid === 1'b1) nv++;
        end
        check("midrst_no_valid", nv, 0);
        deal_inj(4, 5, 6, 7, e0);
        wait_valid("deal_after", v);
        check("after_lat", v - e0, 5);
        check_episode("deal_after", v, model_deal(e0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
